ps_mul_issue: RTL and testbench

PS_MUL_ISSUE -- requirements
Module: ps_mul_issue

---
 rtl/mul_pkg.sv | 46 ++++
 rtl/ps_mul_issue_if.sv | 12 +
 rtl/mul_instr_dec.sv | 23 ++
 rtl/ps_mul_issue.sv | 119 +++++++++++
 tb/tb_ps_mul_issue.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - multiplier instruction fields, class encodings and dtsts bit names
package mul_pkg;

    localparam int INSTR_W   = 20;
    localparam int REG_W     = 4;

    localparam int CLS_HI    = 19;
    localparam int CLS_LO    = 18;
    localparam int DTSTS_HI  = 17;
    localparam int DTSTS_LO  = 14;
    localparam int OTREG_BIT = 13;
    localparam int RSVD_BIT  = 12;
    localparam int RN_HI     = 11;
    localparam int RN_LO     = 8;
    localparam int RX_HI     = 7;
    localparam int RX_LO     = 4;
    localparam int RY_HI     = 3;
    localparam int RY_LO     = 0;

    localparam int DTSTS_RND  = 0;
    localparam int DTSTS_FRAC = 1;
    localparam int DTSTS_XSGN = 2;
    localparam int DTSTS_YSGN = 3;

    typedef enum logic [1:0] {
        CLS_SAT    = 2'b00,
        CLS_MUL    = 2'b01,
        CLS_MACADD = 2'b10,
        CLS_MACSUB = 2'b11
    } cls_e;

    typedef struct packed {
        cls_e             cls;
        logic [3:0]       dtsts;
        logic             otreg;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rx;
        logic [REG_W-1:0] ry;
    } mul_instr_t;

    // Rounding only makes sense on a fractional result.
    function automatic logic is_illegal(input logic [3:0] dtsts);
        return dtsts[DTSTS_RND] & ~dtsts[DTSTS_FRAC];
    endfunction

endpackage

// File: rtl/ps_mul_issue_if.sv
// rtl/ps_mul_issue_if.sv - instruction offer handshake between sequencer and multiplier issue
interface ps_mul_issue_if;
    import mul_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/mul_instr_dec.sv
// rtl/mul_instr_dec.sv - field decode and illegal-combination check for multiplier instructions
module mul_instr_dec
    import mul_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output mul_instr_t         dec,
    output logic               illegal_op
);

    logic unused_rsvd;
    assign unused_rsvd = instr[RSVD_BIT];

    always_comb begin
        dec.cls    = cls_e'(instr[CLS_HI:CLS_LO]);
        dec.dtsts  = instr[DTSTS_HI:DTSTS_LO];
        dec.otreg  = instr[OTREG_BIT];
        dec.rn     = instr[RN_HI:RN_LO];
        dec.rx     = instr[RX_HI:RX_LO];
        dec.ry     = instr[RY_HI:RY_LO];
        illegal_op = is_illegal(instr[DTSTS_HI:DTSTS_LO]);
    end

endmodule

// File: rtl/ps_mul_issue.sv
// rtl/ps_mul_issue.sv - multiplier issue stage with RAW hazard stall, Rn write-back and status flags
// Optional sticky overflow status: define MUL_STICKY_MVS_EN.
module ps_mul_issue
    import mul_pkg::*;
#(
    parameter int RF_DATASIZE = 16,
    parameter int RF_ADDRSIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ps_mul_issue_if.slave          instr_if,
    input  logic                   ps_hold,
    output logic                   ps_mul_en,
    output logic                   ps_mul_otreg,
    output logic [3:0]             ps_mul_dtsts,
    output logic [1:0]             ps_mul_cls,
    output logic [RF_ADDRSIZE-1:0] ps_xb_rx_addr,
    output logic [RF_ADDRSIZE-1:0] ps_xb_ry_addr,
    output logic                   ps_xb_wb_en,
    output logic [RF_ADDRSIZE-1:0] ps_xb_wb_addr,
    input  logic                   mul_ps_ov,
    input  logic                   mul_ps_mn,
    output logic                   astat_mv,
    output logic                   astat_mn,
    output logic                   illegal,
    input  logic                   mvs_clr,
    output logic                   astat_mvs
);

    if (RF_DATASIZE < 1 || RF_ADDRSIZE < REG_W) begin : g_bad_cfg
        $error("ps_mul_issue: unsupported RF_DATASIZE/RF_ADDRSIZE");
    end

    mul_instr_t dec;
    logic       illegal_op;

    mul_instr_dec u_dec (
        .instr      (instr_if.instr),
        .dec        (dec),
        .illegal_op (illegal_op)
    );

    logic             pv_q, pv_d;
    logic             otreg_q, otreg_d;
    logic [REG_W-1:0] rn_q, rn_d;
    logic             astat_mv_q, astat_mv_d;
    logic             astat_mn_q, astat_mn_d;
    logic             hazard, ready, fire, legal_fire;

    always_comb begin
        hazard = pv_q & ~otreg_q & (dec.cls != CLS_SAT) &
                 ((dec.rx == rn_q) | (dec.ry == rn_q));
        // Reset gating keeps the combinational issue path quiet while rst_n is low.
        ready      = rst_n & ~ps_hold & ~hazard;
        fire       = instr_if.instr_valid & ready;
        legal_fire = fire & ~illegal_op;

        ps_mul_en    = legal_fire;
        ps_mul_cls   = legal_fire ? dec.cls   : 2'b00;
        ps_mul_dtsts = legal_fire ? dec.dtsts : 4'b0000;
        ps_mul_otreg = legal_fire ? dec.otreg : 1'b0;
        illegal      = fire & illegal_op;

        ps_xb_rx_addr = RF_ADDRSIZE'(dec.rx);
        ps_xb_ry_addr = RF_ADDRSIZE'(dec.ry);
        ps_xb_wb_en   = pv_q & ~otreg_q;
        ps_xb_wb_addr = RF_ADDRSIZE'(rn_q);

        pv_d    = legal_fire;
        otreg_d = legal_fire ? dec.otreg : otreg_q;
        rn_d    = legal_fire ? dec.rn    : rn_q;

        astat_mv_d = pv_q ? mul_ps_ov : astat_mv_q;
        astat_mn_d = pv_q ? mul_ps_mn : astat_mn_q;
    end

    assign instr_if.instr_ready = ready;
    assign astat_mv             = astat_mv_q;
    assign astat_mn             = astat_mn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q       <= 1'b0;
            otreg_q    <= 1'b0;
            rn_q       <= '0;
            astat_mv_q <= 1'b0;
            astat_mn_q <= 1'b0;
        end else begin
            pv_q       <= pv_d;
            otreg_q    <= otreg_d;
            rn_q       <= rn_d;
            astat_mv_q <= astat_mv_d;
            astat_mn_q <= astat_mn_d;
        end
    end

`ifdef MUL_STICKY_MVS_EN
    logic astat_mvs_q, astat_mvs_d;

    // Set has priority so an overflow landing on the clear cycle is not lost.
    always_comb begin
        astat_mvs_d = astat_mvs_q;
        if (mvs_clr) astat_mvs_d = 1'b0;
        if (pv_q & mul_ps_ov) astat_mvs_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) astat_mvs_q <= 1'b0;
        else        astat_mvs_q <= astat_mvs_d;
    end

    assign astat_mvs = astat_mvs_q;
`else
    logic unused_mvs_clr;
    assign unused_mvs_clr = mvs_clr;
    assign astat_mvs      = 1'b0;
`endif

endmodule

// File: tb/tb_ps_mul_issue.sv
// tb/tb_ps_mul_issue.sv - directed self-checking bench for ps_mul_issue
module tb_ps_mul_issue;
    import mul_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps_hold, mul_ps_ov, mul_ps_mn, mvs_clr;
    logic       ps_mul_en, ps_mul_otreg, ps_xb_wb_en, astat_mv, astat_mn, illegal, astat_mvs;
    logic [3:0] ps_mul_dtsts, ps_xb_rx_addr, ps_xb_ry_addr, ps_xb_wb_addr;
    logic [1:0] ps_mul_cls;
    int         total = 0;
    int         bad = 0;

`ifdef MUL_STICKY_MVS_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    ps_mul_issue_if ifc ();

    ps_mul_issue #(.RF_DATASIZE(16), .RF_ADDRSIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_if(ifc.slave), .ps_hold(ps_hold),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg), .ps_mul_dtsts(ps_mul_dtsts),
        .ps_mul_cls(ps_mul_cls), .ps_xb_rx_addr(ps_xb_rx_addr), .ps_xb_ry_addr(ps_xb_ry_addr),
        .ps_xb_wb_en(ps_xb_wb_en), .ps_xb_wb_addr(ps_xb_wb_addr), .mul_ps_ov(mul_ps_ov),
        .mul_ps_mn(mul_ps_mn), .astat_mv(astat_mv), .astat_mn(astat_mn), .illegal(illegal),
        .mvs_clr(mvs_clr), .astat_mvs(astat_mvs)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] cls, input logic [3:0] dt, input logic ot,
                         input logic [3:0] rn, input logic [3:0] rx, input logic [3:0] ry);
        ifc.instr_valid = 1'b1;
        ifc.instr       = {cls, dt, ot, 1'b0, rn, rx, ry};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ps_hold = 1'b0; mul_ps_ov = 1'b0; mul_ps_mn = 1'b0; mvs_clr = 1'b0;
        ifc.instr_valid = 1'b0; ifc.instr = '0;
        repeat (2) step();
        offer(2'b01, 4'b1110, 1'b0, 4'd3, 4'd1, 4'd2);
        @(negedge clk);
        total++; if (ps_mul_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0h exp=0", ps_mul_en); end
        total++; if (ps_xb_wb_en !== 1'b0) begin bad++; $display("FAIL reset_wb got=%0h exp=0", ps_xb_wb_en); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0h exp=0", illegal); end
        total++; if ({astat_mv, astat_mn, astat_mvs} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%0b exp=000", {astat_mv, astat_mn, astat_mvs}); end
        ifc.instr_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mul_basic();
        offer(2'b01, 4'b1110, 1'b0, 4'd3, 4'd1, 4'd2);
        @(negedge clk);
        total++; if (ps_mul_en !== 1'b1) begin bad++; $display("FAIL basic_en got=%0h exp=1", ps_mul_en); end
        total++; if ({ps_mul_cls, ps_mul_dtsts, ps_mul_otreg} !== 7'b01_1110_0) begin bad++; $display("FAIL basic_ctl got=%0b exp=0111100", {ps_mul_cls, ps_mul_dtsts, ps_mul_otreg}); end
        total++; if ({ps_xb_rx_addr, ps_xb_ry_addr} !== 8'h12) begin bad++; $display("FAIL basic_rdaddr got=%0h exp=12", {ps_xb_rx_addr, ps_xb_ry_addr}); end
        total++; if (ps_xb_wb_en !== 1'b0) begin bad++; $display("FAIL basic_wb_n got=%0h exp=0", ps_xb_wb_en); end
        step();
        ifc.instr_valid = 1'b0; mul_ps_ov = 1'b1; mul_ps_mn = 1'b1;
        @(negedge clk);
        total++; if ({ps_xb_wb_en, ps_xb_wb_addr} !== 5'h13) begin bad++; $display("FAIL basic_wb got=%0h exp=13", {ps_xb_wb_en, ps_xb_wb_addr}); end
        total++; if ({ps_mul_en, ps_mul_cls} !== 3'b000) begin bad++; $display("FAIL basic_idle got=%0b exp=000", {ps_mul_en, ps_mul_cls}); end
        total++; if (astat_mv !== 1'b0) begin bad++; $display("FAIL basic_mv_early got=%0h exp=0", astat_mv); end
        step();
        mul_ps_ov = 1'b0; mul_ps_mn = 1'b0;
        @(negedge clk);
        total++; if ({astat_mv, astat_mn} !== 2'b11) begin bad++; $display("FAIL basic_flags got=%0b exp=11", {astat_mv, astat_mn}); end
        total++; if (astat_mvs !== STICKY) begin bad++; $display("FAIL basic_mvs got=%0h exp=%0h", astat_mvs, STICKY); end
        total++; if (ps_xb_wb_en !== 1'b0) begin bad++; $display("FAIL basic_wb_done got=%0h exp=0", ps_xb_wb_en); end
    endtask

    task automatic test_sticky();
        offer(2'b01, 4'b1110, 1'b1, 4'd7, 4'd0, 4'd0);
        step();
        ifc.instr_valid = 1'b0;
        step();
        @(negedge clk);
        total++; if ({astat_mv, astat_mn} !== 2'b00) begin bad++; $display("FAIL sticky_mv0 got=%0b exp=00", {astat_mv, astat_mn}); end
        total++; if (astat_mvs !== STICKY) begin bad++; $display("FAIL sticky_hold got=%0h exp=%0h", astat_mvs, STICKY); end
        step();
        mvs_clr = 1'b1;
        step();
        mvs_clr = 1'b0;
        @(negedge clk);
        total++; if (astat_mvs !== 1'b0) begin bad++; $display("FAIL sticky_clr got=%0h exp=0", astat_mvs); end
        offer(2'b11, 4'b0110, 1'b1, 4'd7, 4'd0, 4'd0);
        step();
        ifc.instr_valid = 1'b0; mul_ps_ov = 1'b1; mvs_clr = 1'b1;
        step();
        mul_ps_ov = 1'b0; mvs_clr = 1'b0;
        @(negedge clk);
        total++; if (astat_mvs !== STICKY) begin bad++; $display("FAIL sticky_setwins got=%0h exp=%0h", astat_mvs, STICKY); end
        mvs_clr = 1'b1;
        step();
        mvs_clr = 1'b0;
    endtask

    task automatic test_hazard();
        offer(2'b01, 4'b0010, 1'b0, 4'd5, 4'd1, 4'd2);
        @(negedge clk);
        total++; if ({ifc.instr_ready, ps_mul_en} !== 2'b11) begin bad++; $display("FAIL haz_first got=%0b exp=11", {ifc.instr_ready, ps_mul_en}); end
        step();
        offer(2'b01, 4'b0010, 1'b0, 4'd6, 4'd5, 4'd0);
        @(negedge clk);
        total++; if ({ifc.instr_ready, ps_mul_en} !== 2'b00) begin bad++; $display("FAIL haz_stall got=%0b exp=00", {ifc.instr_ready, ps_mul_en}); end
        total++; if ({ps_xb_wb_en, ps_xb_wb_addr} !== 5'h15) begin bad++; $display("FAIL haz_wb got=%0h exp=15", {ps_xb_wb_en, ps_xb_wb_addr}); end
        step();
        @(negedge clk);
        total++; if ({ifc.instr_ready, ps_mul_en, ps_xb_rx_addr} !== 6'b11_0101) begin bad++; $display("FAIL haz_issue got=%0b exp=110101", {ifc.instr_ready, ps_mul_en, ps_xb_rx_addr}); end
        step();
        offer(2'b00, 4'b0000, 1'b0, 4'd9, 4'd6, 4'd6);
        @(negedge clk);
        total++; if ({ifc.instr_ready, ps_mul_en, ps_xb_wb_addr} !== 6'b11_0110) begin bad++; $display("FAIL haz_sat got=%0b exp=110110", {ifc.instr_ready, ps_mul_en, ps_xb_wb_addr}); end
        step();
        offer(2'b10, 4'b0010, 1'b0, 4'd1, 4'd0, 4'd9);
        @(negedge clk);
        total++; if ({ifc.instr_ready, ps_mul_en} !== 2'b00) begin bad++; $display("FAIL haz_ry got=%0b exp=00", {ifc.instr_ready, ps_mul_en}); end
        step();
        ifc.instr_valid = 1'b0;
        step();
    endtask

    task automatic test_otreg();
        offer(2'b10, 4'b1110, 1'b1, 4'd9, 4'd1, 4'd1);
        step();
        offer(2'b01, 4'b1110, 1'b0, 4'd2, 4'd9, 4'd9);
        @(negedge clk);
        total++; if ({ifc.instr_ready, ps_mul_en} !== 2'b11) begin bad++; $display("FAIL otreg_nostall got=%0b exp=11", {ifc.instr_ready, ps_mul_en}); end
        total++; if (ps_xb_wb_en !== 1'b0) begin bad++; $display("FAIL otreg_nowb got=%0h exp=0", ps_xb_wb_en); end
        step();
        ifc.instr_valid = 1'b0;
        @(negedge clk);
        total++; if ({ps_xb_wb_en, ps_xb_wb_addr} !== 5'h12) begin bad++; $display("FAIL otreg_next_wb got=%0h exp=12", {ps_xb_wb_en, ps_xb_wb_addr}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] rns [4];
        rns = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 4; i++) begin
            offer(2'b01, 4'b1100, 1'b0, rns[i], 4'd10 + 4'(i), 4'd14);
            @(negedge clk);
            total++; if ({ifc.instr_ready, ps_mul_en} !== 2'b11) begin bad++; $display("FAIL b2b_issue%0d got=%0b exp=11", i, {ifc.instr_ready, ps_mul_en}); end
            if (i > 0) begin
                total++; if ({ps_xb_wb_en, ps_xb_wb_addr} !== {1'b1, rns[i-1]}) begin bad++; $display("FAIL b2b_wb%0d got=%0h exp=%0h", i, {ps_xb_wb_en, ps_xb_wb_addr}, {1'b1, rns[i-1]}); end
            end
            step();
        end
        ifc.instr_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        offer(2'b01, 4'b0001, 1'b0, 4'd8, 4'd1, 4'd2);
        @(negedge clk);
        total++; if ({ifc.instr_ready, illegal, ps_mul_en} !== 3'b110) begin bad++; $display("FAIL illegal_pulse got=%0b exp=110", {ifc.instr_ready, illegal, ps_mul_en}); end
        total++; if ({ps_mul_cls, ps_mul_dtsts} !== 6'b0) begin bad++; $display("FAIL illegal_ctl got=%0h exp=0", {ps_mul_cls, ps_mul_dtsts}); end
        step();
        offer(2'b01, 4'b0010, 1'b0, 4'd3, 4'd8, 4'd8);
        @(negedge clk);
        total++; if ({illegal, ps_xb_wb_en, ifc.instr_ready} !== 3'b001) begin bad++; $display("FAIL illegal_after got=%0b exp=001", {illegal, ps_xb_wb_en, ifc.instr_ready}); end
        step();
        ifc.instr_valid = 1'b0;
        step();
    endtask

    task automatic test_hold();
        offer(2'b01, 4'b1110, 1'b0, 4'd11, 4'd0, 4'd0);
        step();
        ps_hold = 1'b1; mul_ps_ov = 1'b1;
        offer(2'b01, 4'b1110, 1'b0, 4'd13, 4'd0, 4'd0);
        @(negedge clk);
        total++; if ({ifc.instr_ready, ps_mul_en} !== 2'b00) begin bad++; $display("FAIL hold_block got=%0b exp=00", {ifc.instr_ready, ps_mul_en}); end
        total++; if ({ps_xb_wb_en, ps_xb_wb_addr} !== 5'h1b) begin bad++; $display("FAIL hold_drain got=%0h exp=1b", {ps_xb_wb_en, ps_xb_wb_addr}); end
        step();
        ps_hold = 1'b0;
        @(negedge clk);
        total++; if ({astat_mv, ps_mul_en, ps_xb_wb_en} !== 3'b110) begin bad++; $display("FAIL hold_release got=%0b exp=110", {astat_mv, ps_mul_en, ps_xb_wb_en}); end
        step();
        ifc.instr_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        offer(2'b01, 4'b1110, 1'b0, 4'd12, 4'd0, 4'd0);
        step();
        ifc.instr_valid = 1'b0; mul_ps_ov = 1'b1; mul_ps_mn = 1'b1;
        @(negedge clk);
        total++; if ({ps_xb_wb_en, ps_xb_wb_addr} !== 5'h1c) begin bad++; $display("FAIL rmid_pre got=%0h exp=1c", {ps_xb_wb_en, ps_xb_wb_addr}); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (ps_xb_wb_en !== 1'b0) begin bad++; $display("FAIL rmid_wb got=%0h exp=0", ps_xb_wb_en); end
        total++; if ({astat_mv, astat_mn, astat_mvs} !== 3'b000) begin bad++; $display("FAIL rmid_flags got=%0b exp=000", {astat_mv, astat_mn, astat_mvs}); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({ps_xb_wb_en, astat_mv, astat_mn} !== 3'b000) begin bad++; $display("FAIL rmid_after got=%0b exp=000", {ps_xb_wb_en, astat_mv, astat_mn}); end
        step();
        mul_ps_ov = 1'b0; mul_ps_mn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_sticky();
        test_hazard();
        test_otreg();
        test_back_to_back();
        test_illegal();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
